// File: rtl/fab_cfg_serializer_if.sv
// Bitstream word handshake between a bitstream source and fab_cfg_serializer.
//   word_data  : 32-bit bitstream word, bit 31 shifted first
//   word_valid : source has a word available
//   word_last  : marks the final word of the bitstream (qualified by word_valid)
//   word_ready : serializer can accept a word
// master = bitstream source, slave = serializer.
interface fab_cfg_serializer_if;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_last;
  logic        word_ready;

  modport master (output word_data, output word_valid, output word_last, input word_ready);
  modport slave  (input word_data, input word_valid, input word_last, output word_ready);
endinterface

// File: rtl/fab_cfg_serializer.sv
// Configuration-load sequencer: shifts 32-bit bitstream words MSB first onto the
// fabric serial config port, each data bit followed by the matching control-word bit.
// Ports:
//   CLK, reset  : clock and synchronous active-high reset
//   src         : word handshake (slave side)
//   abort       : synchronous cancel, returns to IDLE with s_clk/s_data low
//   s_clk       : serial config clock to the fabric (registered)
//   s_data      : serial config data to the fabric (registered)
//   busy        : high whenever not IDLE
//   done        : one-cycle pulse after the tail of the final word
//   words_sent  : saturating count of fully shifted words
module fab_cfg_serializer #(
  parameter logic [31:0] CTRL_WORD    = 32'h0000FAB1,
  parameter int unsigned PHASE_CYCLES = 1,
  parameter int unsigned TAIL_CYCLES  = 100
) (
  input  logic                 CLK,
  input  logic                 reset,
  fab_cfg_serializer_if.slave  src,
  input  logic                 abort,
  output logic                 s_clk,
  output logic                 s_data,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          words_sent
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FALL_LAST  = CNT_W'(2 * PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(TAIL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RISE  = 3'd2,
    HOLD  = 3'd3,
    FALL  = 3'd4,
    TAIL  = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       bit_idx;
  logic [31:0]      data_sh;   // latched word, current data bit at [31]
  logic [31:0]      ctrl_sh;   // control word, current control bit at [31]
  logic             last_q;
  logic             ready_q;

  assign src.word_ready = ready_q;

  // Sequencer: every output is loaded on the edge that enters the phase it belongs to.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data_sh    <= '0;
      ctrl_sh    <= '0;
      last_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      s_clk      <= 1'b0;
      s_data     <= 1'b0;
      words_sent <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Cancel wins over a same-cycle accept; partial word is not counted.
        state   <= IDLE;
        cnt     <= '0;
        ready_q <= 1'b1;
        busy    <= 1'b0;
        s_clk   <= 1'b0;
        s_data  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // ready_q is always set in IDLE, so valid alone completes the handshake.
            if (src.word_valid) begin
              data_sh <= src.word_data;
              ctrl_sh <= CTRL_WORD;
              last_q  <= src.word_last;
              bit_idx <= '0;
              cnt     <= '0;
              s_data  <= src.word_data[31];
              s_clk   <= 1'b0;
              ready_q <= 1'b0;
              busy    <= 1'b1;
              state   <= SETUP;
            end
          end
          SETUP: begin
            if (cnt == PHASE_LAST) begin
              cnt   <= '0;
              s_clk <= 1'b1;
              state <= RISE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RISE: begin
            if (cnt == PHASE_LAST) begin
              cnt    <= '0;
              s_data <= ctrl_sh[31];
              state  <= HOLD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          HOLD: begin
            if (cnt == PHASE_LAST) begin
              cnt   <= '0;
              s_clk <= 1'b0;
              state <= FALL;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          FALL: begin
            if (cnt == FALL_LAST) begin
              cnt <= '0;
              if (bit_idx != 5'd31) begin
                bit_idx <= bit_idx + 5'd1;
                data_sh <= {data_sh[30:0], 1'b0};
                ctrl_sh <= {ctrl_sh[30:0], 1'b0};
                s_data  <= data_sh[30];
                state   <= SETUP;
              end else begin
                if (words_sent != 16'hFFFF) begin
                  words_sent <= words_sent + 16'd1;
                end
                if (last_q) begin
                  state <= TAIL;
                end else begin
                  ready_q <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
                end
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          TAIL: begin
            if (cnt == TAIL_LAST) begin
              cnt     <= '0;
              done    <= 1'b1;
              ready_q <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            s_clk   <= 1'b0;
            s_data  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fab_cfg_serializer.sv
// Self-checking bench for fab_cfg_serializer: a P=1/TAIL=100 instance with a
// scoreboard monitor, and a P=3/TAIL=4 instance checked for phase timing.
module tb_fab_cfg_serializer;

  localparam logic [31:0] CTRL  = 32'h0000FAB1;
  localparam int          TAIL0 = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        abort0;
  logic        abort1;
  logic        s_clk0, s_data0, busy0, done0;
  logic        s_clk1, s_data1, busy1, done1;
  logic [15:0] words_sent0, words_sent1;

  fab_cfg_serializer_if bus0 ();
  fab_cfg_serializer_if bus1 ();

  fab_cfg_serializer #(.CTRL_WORD(CTRL), .PHASE_CYCLES(1), .TAIL_CYCLES(TAIL0)) dut0 (
    .CLK(clk), .reset(reset), .src(bus0), .abort(abort0),
    .s_clk(s_clk0), .s_data(s_data0), .busy(busy0), .done(done0), .words_sent(words_sent0)
  );

  fab_cfg_serializer #(.CTRL_WORD(CTRL), .PHASE_CYCLES(3), .TAIL_CYCLES(4)) dut1 (
    .CLK(clk), .reset(reset), .src(bus1), .abort(abort1),
    .s_clk(s_clk1), .s_data(s_data1), .busy(busy1), .done(done1), .words_sent(words_sent1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard state for dut0
  bit exp_d_q[$];
  bit exp_c_q[$];
  int exp_done_cyc = -1;
  int busy_chk_cyc = -1;
  int rises        = 0;
  int rise_in_word = 0;
  int prev_rise    = 0;
  int high_len     = 0;
  int done_cnt     = 0;
  bit prev_sclk    = 1'b0;

  always @(negedge clk) begin
    bit e;
    if (s_clk0 && !prev_sclk) begin
      check("rise_q_nonempty", 32'(exp_d_q.size() != 0), 32'd1);
      if (exp_d_q.size() != 0) begin
        e = exp_d_q.pop_front();
        check("data_at_rise", 32'(s_data0), 32'(e));
      end
      if (rise_in_word > 0) check("bit_period", 32'(cyc - prev_rise), 32'd5);
      rise_in_word++;
      prev_rise = cyc;
      rises++;
      high_len = 1;
    end else if (s_clk0 && prev_sclk) begin
      high_len++;
      if (high_len == 2 && exp_c_q.size() != 0)
        check("ctrl_in_hold", 32'(s_data0), 32'(exp_c_q[0]));
    end else if (!s_clk0 && prev_sclk) begin
      check("high_len", 32'(high_len), 32'd2);
      check("fall_q_nonempty", 32'(exp_c_q.size() != 0), 32'd1);
      if (exp_c_q.size() != 0) begin
        e = exp_c_q.pop_front();
        check("ctrl_in_fall", 32'(s_data0), 32'(e));
      end
    end
    prev_sclk = s_clk0;

    if (done0) begin
      done_cnt++;
      check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
      check("busy_at_done", 32'(busy0), 32'd0);
      exp_done_cyc = -1;
    end else if (exp_done_cyc >= 0 && cyc == exp_done_cyc) begin
      check("done_pulse", 32'(done0), 32'd1);
      exp_done_cyc = -1;
    end
    if (busy_chk_cyc >= 0 && cyc == busy_chk_cyc) begin
      check("busy_after_accept", 32'(busy0), 32'd1);
      busy_chk_cyc = -1;
    end

    if (reset || abort0) begin
      exp_d_q.delete();
      exp_c_q.delete();
      exp_done_cyc = -1;
      busy_chk_cyc = -1;
      prev_sclk    = 1'b0;
    end else if (bus0.word_valid && bus0.word_ready) begin
      for (int j = 0; j < 32; j++) begin
        exp_d_q.push_back(bus0.word_data[31-j]);
        exp_c_q.push_back(CTRL[31-j]);
      end
      rise_in_word = 0;
      busy_chk_cyc = cyc + 1;
      if (bus0.word_last) exp_done_cyc = cyc + 160 + TAIL0 + 1;
    end
  end

  // Present a word on bus0 and return the cycle in which it was accepted.
  task automatic send0(input logic [31:0] w, input logic last, output int acc);
    acc = -1;
    @(posedge clk); #1;
    bus0.word_valid = 1'b1;
    bus0.word_data  = w;
    bus0.word_last  = last;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus0.word_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check("send0_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus0.word_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen);
    int d0;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy0) begin
        idle = 1'b1;
        break;
      end
    end
    check("wait_idle", 32'(idle), 32'd1);
  endtask

  bit p1_done = 1'b0;

  // P=3 instance: bit period, clock-high width and word length.
  initial begin
    int a1, busy_cnt, high_total, r0, r1, first_high, nrise;
    bit prev, got, fell, d_r0, d_r1, d_r2;
    abort1 = 1'b0;
    bus1.word_valid = 1'b0;
    bus1.word_data  = '0;
    bus1.word_last  = 1'b0;
    @(negedge clk);
    while (reset) @(negedge clk);
    @(posedge clk); #1;
    bus1.word_valid = 1'b1;
    bus1.word_data  = 32'hC0000000;
    bus1.word_last  = 1'b0;
    a1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.word_ready) begin a1 = cyc; break; end
    end
    check("p3_accept", 32'(a1 >= 0), 32'd1);
    @(posedge clk); #1;
    bus1.word_valid = 1'b0;
    busy_cnt = 0; high_total = 0; r0 = -1; r1 = -1; first_high = 0;
    nrise = 0; prev = 1'b0; fell = 1'b0; got = 1'b0;
    d_r0 = 1'b0; d_r1 = 1'b0; d_r2 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy1) begin got = 1'b1; break; end
      busy_cnt++;
      if (s_clk1) high_total++;
      if (s_clk1 && !fell) first_high++;
      if (!s_clk1 && prev) fell = 1'b1;
      if (s_clk1 && !prev) begin
        if (nrise == 0) begin r0 = cyc; d_r0 = s_data1; end
        if (nrise == 1) begin r1 = cyc; d_r1 = s_data1; end
        if (nrise == 2) d_r2 = s_data1;
        nrise++;
      end
      prev = s_clk1;
    end
    check("p3_idle_reached", 32'(got), 32'd1);
    check("p3_word_cycles", 32'(busy_cnt), 32'd480);
    check("p3_first_rise", 32'(r0 - a1), 32'd4);
    check("p3_bit_period", 32'(r1 - r0), 32'd15);
    check("p3_high_width", 32'(first_high), 32'd6);
    check("p3_high_total", 32'(high_total), 32'd192);
    check("p3_rises", 32'(nrise), 32'd32);
    check("p3_bit0", 32'(d_r0), 32'd1);
    check("p3_bit1", 32'(d_r1), 32'd1);
    check("p3_bit2", 32'(d_r2), 32'd0);
    check("p3_words_sent", 32'(words_sent1), 32'd1);
    check("p3_no_done", 32'(done_cnt >= 0 && !done1), 32'd1);
    p1_done = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a1, a2, rb, d0, ws;
    bit seen;
    reset  = 1'b1;
    abort0 = 1'b0;
    bus0.word_valid = 1'b0;
    bus0.word_data  = '0;
    bus0.word_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_s_clk", 32'(s_clk0), 32'd0);
    check("rst_s_data", 32'(s_data0), 32'd0);
    check("rst_ready", 32'(bus0.word_ready), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_words", 32'(words_sent0), 32'd0);

    // Single last word
    rb = rises;
    send0(32'hA5000000, 1'b1, a);
    wait_done(400, seen);
    check("t1_done_seen", 32'(seen), 32'd1);
    check("t1_rises", 32'(rises - rb), 32'd32);
    check("t1_words", 32'(words_sent0), 32'd1);

    // Back-to-back words with valid held high
    @(posedge clk); #1;
    bus0.word_valid = 1'b1;
    bus0.word_data  = 32'h0F1E2D3C;
    bus0.word_last  = 1'b0;
    a1 = -1; a2 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.word_ready) begin a1 = cyc; break; end
    end
    @(posedge clk); #1;
    bus0.word_data = 32'hDEADBEEF;
    bus0.word_last = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus0.word_ready) begin a2 = cyc; break; end
    end
    @(posedge clk); #1;
    bus0.word_valid = 1'b0;
    check("b2b_gap", 32'(a2 - a1), 32'd161);
    d0 = done_cnt;
    wait_done(400, seen);
    repeat (20) @(negedge clk);
    check("b2b_done_once", 32'(done_cnt - d0), 32'd1);
    check("b2b_words", 32'(words_sent0), 32'd3);

    // Abort while s_clk is high in bit 10, with a new word offered
    d0 = done_cnt;
    send0(32'h12345678, 1'b1, a);
    while (cyc < a + 51) @(negedge clk);
    @(posedge clk); #1;
    ws = 32'(words_sent0);
    abort0 = 1'b1;
    bus0.word_valid = 1'b1;
    bus0.word_data  = 32'hFFFFFFFF;
    bus0.word_last  = 1'b1;
    @(negedge clk);
    check("abort_pre_s_clk", 32'(s_clk0), 32'd1);
    check("abort_pre_s_data", 32'(s_data0), 32'd1);
    @(posedge clk); #1;
    abort0 = 1'b0;
    bus0.word_valid = 1'b0;
    @(negedge clk);
    check("abort_s_clk", 32'(s_clk0), 32'd0);
    check("abort_s_data", 32'(s_data0), 32'd0);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_ready", 32'(bus0.word_ready), 32'd1);
    check("abort_words", 32'(words_sent0), 32'(ws));
    repeat (300) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_words_later", 32'(words_sent0), 32'(ws));

    // Reset during bit 20, then a fresh word
    send0(32'hFFFFFFFF, 1'b1, a);
    while (cyc < a + 101) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset_pre_s_clk", 32'(s_clk0), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst2_s_clk", 32'(s_clk0), 32'd0);
    check("rst2_s_data", 32'(s_data0), 32'd0);
    check("rst2_busy", 32'(busy0), 32'd0);
    check("rst2_ready", 32'(bus0.word_ready), 32'd1);
    check("rst2_done", 32'(done0), 32'd0);
    check("rst2_words", 32'(words_sent0), 32'd0);
    rb = rises;
    send0(32'h3C00F00D, 1'b0, a);
    wait_idle(400);
    check("rst2_rises", 32'(rises - rb), 32'd32);
    check("rst2_words_after", 32'(words_sent0), 32'd1);

    // Saturation from 16'hFFFE
    @(posedge clk); #1;
    force dut0.words_sent = 16'hFFFE;
    @(posedge clk); #1;
    release dut0.words_sent;
    @(negedge clk);
    check("sat_preload", 32'(words_sent0), 32'h0000FFFE);
    send0(32'h00000000, 1'b0, a);
    wait_idle(400);
    check("sat_word1", 32'(words_sent0), 32'h0000FFFF);
    send0(32'h80000001, 1'b0, a);
    wait_idle(400);
    check("sat_word2", 32'(words_sent0), 32'h0000FFFF);
    send0(32'h55555555, 1'b0, a);
    wait_idle(400);
    check("sat_word3", 32'(words_sent0), 32'h0000FFFF);

    for (int i = 0; i < 2000 && !p1_done; i++) @(negedge clk);
    check("p3_finished", 32'(p1_done), 32'd1);
    check("sb_data_drained", 32'(exp_d_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
